alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle_pkg.sv | 68 ++++++
 rtl/alu_shift_step.sv | 33 +++
 rtl/alu_multicycle.sv | 88 ++++++++
 tb/tb_alu_multicycle.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU: op codes, shift kinds and the
// single-cycle result function used when an operation is accepted.
package alu_multicycle_pkg;

  localparam int DATA_W = 32;

  // ALUop encoding shared with the stage-2 decoder; 4'hB..4'hE are unencoded.
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLT    = 4'h5;
  localparam logic [3:0] ALU_SLTU   = 4'h6;
  localparam logic [3:0] ALU_SLL    = 4'h7;
  localparam logic [3:0] ALU_SRL    = 4'h8;
  localparam logic [3:0] ALU_SRA    = 4'h9;
  localparam logic [3:0] ALU_COPY_B = 4'hA;
  localparam logic [3:0] ALU_XXX    = 4'hF;

  typedef enum logic [1:0] {
    SHIFT_LEFT        = 2'd0,
    SHIFT_RIGHT_LOGIC = 2'd1,
    SHIFT_RIGHT_ARITH = 2'd2
  } shift_kind_t;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              err;
  } alu_out_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic shift_kind_t shift_kind_of(input logic [3:0] op);
    shift_kind_t kind;
    kind = SHIFT_LEFT;
    if (op == ALU_SRL) kind = SHIFT_RIGHT_LOGIC;
    else if (op == ALU_SRA) kind = SHIFT_RIGHT_ARITH;
    return kind;
  endfunction

  // Shift ops return a unchanged: it is the starting value of the bit-serial shift.
  function automatic alu_out_t alu_eval(input logic [3:0] op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_out_t r;
    r.value = '0;
    r.err   = 1'b0;
    case (op)
      ALU_ADD:    r.value = a + b;
      ALU_SUB:    r.value = a - b;
      ALU_AND:    r.value = a & b;
      ALU_OR:     r.value = a | b;
      ALU_XOR:    r.value = a ^ b;
      ALU_SLT:    r.value = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   r.value = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:    r.value = a;
      ALU_COPY_B: r.value = b;
      default:    r.err   = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shift of a 32-bit value: left, logical right or
// arithmetic right.
module alu_shift_step
  import alu_multicycle_pkg::*;
(
  input  logic [31:0] value,
  input  shift_kind_t kind,
  output logic [31:0] shifted
);

  logic fill;
  assign fill = (kind == SHIFT_RIGHT_ARITH) ? value[31] : 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      logic from_left;
      logic from_right;
      if (gi == 0) begin : g_lsb
        assign from_left = 1'b0;
      end else begin : g_lo
        assign from_left = value[gi-1];
      end
      if (gi == 31) begin : g_msb
        assign from_right = fill;
      end else begin : g_hi
        assign from_right = value[gi+1];
      end
      assign shifted[gi] = (kind == SHIFT_LEFT) ? from_left : from_right;
    end
  endgenerate

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts, and a
// valid/ready handshake on both sides with a synchronous kill.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  shift_kind_t kind;
  logic [4:0]  count;
  logic        accept;
  alu_out_t    alu_res;
  logic [31:0] shift_next;

  assign in_ready  = (state == IDLE) && !kill;
  assign out_valid = (state == DONE) && !kill;
  assign accept    = in_valid && in_ready;
  assign alu_res   = alu_eval(alu_op, a, b);

  // The result register doubles as the shift register while in SHIFT.
  alu_shift_step u_shift_step (
    .value   (result),
    .kind    (kind),
    .shifted (shift_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      kind   <= SHIFT_LEFT;
      count  <= 5'd0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            result <= alu_res.value;
            err    <= alu_res.err;
            kind   <= shift_kind_of(alu_op);
            if (is_shift_op(alu_op) && (b[4:0] != 5'd0)) begin
              count <= b[4:0];
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (kill) begin
            count <= 5'd0;
            state <= IDLE;
          end else begin
            result <= shift_next;
            count  <= count - 5'd1;
            if (count == 5'd1) state <= DONE;
          end
        end
        DONE: begin
          // kill takes priority over a pending transfer
          if (kill || out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed self-checking bench for alu_multicycle against a
// plain-arithmetic reference model.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    int sh;
    sh = int'(y[4:0]);
    case (op)
      ALU_ADD:    r = x + y;
      ALU_SUB:    r = x - y;
      ALU_AND:    r = x & y;
      ALU_OR:     r = x | y;
      ALU_XOR:    r = x ^ y;
      ALU_SLT:    r = ($signed(x) < $signed(y)) ? 32'h1 : 32'h0;
      ALU_SLTU:   r = (x < y) ? 32'h1 : 32'h0;
      ALU_SLL:    r = x << sh;
      ALU_SRL:    r = x >> sh;
      ALU_SRA:    r = 32'($signed(x) >>> sh);
      ALU_COPY_B: r = y;
      default:    r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic model_err(input logic [3:0] op);
    return (op > ALU_COPY_B);
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [31:0] y);
    if ((op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && y[4:0] != 5'd0)
      return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // One full transaction: accept, wait for result, hold with out_ready low, transfer.
  task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input int hold);
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          k;
    er  = model_result(op, av, bv);
    ee  = model_err(op);
    lat = model_latency(op, bv);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; a = av; b = bv; out_ready = 1'b0; kill = 1'b0;
    #1 check_eq("in_ready_accept", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
    #1;
    k = 1;
    while (!out_valid && k < 40) begin
      check_eq("in_ready_busy", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("latency", 32'(k), 32'(lat));
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", {31'b0, out_valid}, 32'h1);
      check_eq("hold_result", result, er);
      check_eq("hold_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = ALU_ADD;
    #1;
    check_eq("xfer_valid", {31'b0, out_valid}, 32'h1);
    check_eq("xfer_result", result, er);
    check_eq("xfer_err", {31'b0, err}, {31'b0, ee});
    check_eq("xfer_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check_eq("post_valid", {31'b0, out_valid}, 32'h0);
    check_eq("post_in_ready", {31'b0, in_ready}, 32'h1);
    $display("op=%h a=%h b=%h hold=%0d result=%h err=%0d latency=%0d", op, av, bv, hold, result, err, k);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; alu_op = 4'h0; a = '0; b = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_eq("rst_in_ready", {31'b0, in_ready}, 32'h1);

    do_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(ALU_SRA, 32'h8000_0000, 32'h0000_001F, 0);
    do_op(ALU_SRL, 32'h8000_0000, 32'h0000_001F, 1);
    do_op(ALU_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 0);
    do_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(ALU_SUB, 32'd5, 32'd7, 4);
    do_op(ALU_XXX, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    do_op(4'hC, 32'h1, 32'h2, 0);
    do_op(ALU_COPY_B, 32'h1, 32'hCAFE_F00D, 0);

    // Kill mid-shift: SLL shamt=10 killed in N+4
    @(negedge clk);
    in_valid = 1'b1; alu_op = ALU_SLL; a = 32'h0000_0001; b = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1 check_eq("kill_shift_nv", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
    end
    kill = 1'b1;
    #1;
    check_eq("kill_shift_valid", {31'b0, out_valid}, 32'h0);
    check_eq("kill_shift_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check_eq("kill_shift_idle", {31'b0, in_ready}, 32'h1);
    for (int c = 0; c < 12; c++) begin
      check_eq("kill_shift_ghost", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
      #1;
    end
    $display("kill in SHIFT done");

    // Kill in DONE wins over out_ready
    @(negedge clk);
    in_valid = 1'b1; alu_op = ALU_ADD; a = 32'd3; b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_eq("kill_done_pre", {31'b0, out_valid}, 32'h1);
    kill = 1'b1; out_ready = 1'b1;
    #1 check_eq("kill_done_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    kill = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("kill_done_idle", {31'b0, in_ready}, 32'h1);
    check_eq("kill_done_ghost", {31'b0, out_valid}, 32'h0);
    $display("kill in DONE done");

    // Kill in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; alu_op = ALU_OR; kill = 1'b1;
    #1 check_eq("kill_idle_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    #1;
    check_eq("kill_idle_noacc", {31'b0, out_valid}, 32'h0);
    check_eq("kill_idle_ready2", {31'b0, in_ready}, 32'h1);
    $display("kill in IDLE done");

    // Reset mid-shift discards the operation
    @(negedge clk);
    in_valid = 1'b1; alu_op = ALU_SRL; a = 32'hFFFF_0000; b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    check_eq("rst_mid_result", result, 32'h0);
    check_eq("rst_mid_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_eq("rst_mid_ready", {31'b0, in_ready}, 32'h1);
    for (int c = 0; c < 25; c++) begin
      check_eq("rst_mid_ghost", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
      #1;
    end
    $display("reset mid-shift done");

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      do_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
